// File: rtl/rtx_mcp_pkg.sv
// Shared types and Gray-code helpers for the two-slot transmit side of the
// rtx_mcp clock-crossing link.
package rtx_mcp_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    PART  = 2'd1,
    FULL  = 2'd2
  } status_e;

  // 2-bit binary to reflected Gray code.
  function automatic logic [1:0] bin2gray(input logic [1:0] b);
    return b ^ {1'b0, b[1]};
  endfunction

  // 2-bit reflected Gray code back to binary.
  function automatic logic [1:0] gray2bin(input logic [1:0] g);
    return {g[1], g[1] ^ g[0]};
  endfunction

endpackage

// File: rtl/rtx_mcp_if.sv
// Bundle of the source handshake, remote pointer crossing and status signals.
// The transmitter (rtx_mcp) is the slave; the source/remote environment is the master.
interface rtx_mcp_if #(
  parameter int WIDTH = 8
);

  logic               rput;
  logic [WIDTH-1:0]   rdata;
  logic               rclr;
  logic [1:0]         rq2_aptr;
  logic               rrdy;
  logic [1:0]         tptr;
  logic [2*WIDTH-1:0] tdata;
  logic [1:0]         rstatus;
  logic               rovf;
  logic               rperr;

  modport master (
    output rput, rdata, rclr, rq2_aptr,
    input  rrdy, tptr, tdata, rstatus, rovf, rperr
  );

  modport slave (
    input  rput, rdata, rclr, rq2_aptr,
    output rrdy, tptr, tdata, rstatus, rovf, rperr
  );

endinterface

// File: rtl/rtx_mcp_tx_mem2.sv
// Two-entry register file holding the words in flight; both entries are
// exposed so the remote side can pick one with its own pointer.
module tx_mem2 #(
  parameter int WIDTH = 8
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             we_i,
  input  logic             addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] ent0_o,
  output logic [WIDTH-1:0] ent1_o
);

  logic [WIDTH-1:0] ent0_q;
  logic [WIDTH-1:0] ent1_q;

  // Write the addressed entry on we_i; the other entry keeps its value.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      ent0_q <= '0;
      ent1_q <= '0;
    end else if (we_i) begin
      if (addr_i) begin
        ent1_q <= wdata_i;
      end else begin
        ent0_q <= wdata_i;
      end
    end
  end

  assign ent0_o = ent0_q;
  assign ent1_o = ent1_q;

endmodule

// File: rtl/rtx_mcp.sv
// Transmit side of a two-slot multi-cycle-path crossing: Gray pointer to the
// remote receiver, occupancy tracking against the synchronized ack pointer,
// and sticky overflow / pointer-error flags.
module rtx_mcp
  import rtx_mcp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic     rclk,
  input logic     rrst_n,
  rtx_mcp_if.slave bus
);

  logic [1:0]       tbin_q;
  logic [1:0]       tbin_d;
  logic [1:0]       tptr_q;
  logic [1:0]       tptr_d;
  logic             rovf_q;
  logic             rovf_d;
  logic             rperr_q;
  logic             rperr_d;
  logic [1:0]       abin_s;
  logic [1:0]       count_s;
  logic             full_s;
  logic             ahead_s;
  logic             rrdy_s;
  logic             rinc_s;
  status_e          status_s;
  logic [WIDTH-1:0] slot0_s;
  logic [WIDTH-1:0] slot1_s;

  // Occupancy from our binary pointer and the remote ack pointer; count 3
  // can only mean the remote side ran ahead, so it blocks puts too.
  always_comb begin
    abin_s  = gray2bin(bus.rq2_aptr);
    count_s = tbin_q - abin_s;
    full_s  = (tptr_q == ~bus.rq2_aptr);
    ahead_s = (count_s == 2'd3);
    rrdy_s  = ~full_s & ~ahead_s;
    rinc_s  = bus.rput & rrdy_s;
    case (count_s)
      2'd0:    status_s = EMPTY;
      2'd1:    status_s = PART;
      default: status_s = FULL;
    endcase
  end

  // Next pointer and sticky flags; a set condition beats a same-cycle clear.
  always_comb begin
    tbin_d  = tbin_q;
    tptr_d  = tptr_q;
    rovf_d  = rovf_q;
    rperr_d = rperr_q;
    if (rinc_s) begin
      tbin_d = tbin_q + 2'd1;
      tptr_d = bin2gray(tbin_q + 2'd1);
    end else begin
      tbin_d = tbin_q;
      tptr_d = tptr_q;
    end
    if (bus.rput && full_s) begin
      rovf_d = 1'b1;
    end else if (bus.rclr) begin
      rovf_d = 1'b0;
    end else begin
      rovf_d = rovf_q;
    end
    if (ahead_s) begin
      rperr_d = 1'b1;
    end else if (bus.rclr) begin
      rperr_d = 1'b0;
    end else begin
      rperr_d = rperr_q;
    end
  end

  // Pointer and flag registers, cleared asynchronously.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      tbin_q  <= 2'd0;
      tptr_q  <= 2'd0;
      rovf_q  <= 1'b0;
      rperr_q <= 1'b0;
    end else begin
      tbin_q  <= tbin_d;
      tptr_q  <= tptr_d;
      rovf_q  <= rovf_d;
      rperr_q <= rperr_d;
    end
  end

  tx_mem2 #(
    .WIDTH (WIDTH)
  ) u_mem (
    .rclk    (rclk),
    .rrst_n  (rrst_n),
    .we_i    (rinc_s),
    .addr_i  (tbin_q[0]),
    .wdata_i (bus.rdata),
    .ent0_o  (slot0_s),
    .ent1_o  (slot1_s)
  );

  assign bus.rrdy    = rrdy_s;
  assign bus.tptr    = tptr_q;
  assign bus.tdata   = {slot1_s, slot0_s};
  assign bus.rstatus = status_s;
  assign bus.rovf    = rovf_q;
  assign bus.rperr   = rperr_q;

endmodule

// File: tb/tb_rtx_mcp.sv
// Bench for rtx_mcp: directed scenarios plus a randomized run with a modelled
// remote receiver that acknowledges words and checks them against a queue.
module tb_rtx_mcp;

  localparam int W = 8;

  logic rclk   = 1'b0;
  logic rrst_n = 1'b0;

  rtx_mcp_if #(.WIDTH(W)) bus ();

  rtx_mcp #(.WIDTH(W)) dut (
    .rclk   (rclk),
    .rrst_n (rrst_n),
    .bus    (bus.slave)
  );

  always #5 rclk = ~rclk;

  int checks   = 0;
  int failures = 0;

  // Reference model: counts of accepted words and acknowledged words.
  int             wr;
  int             rd;
  int             ab;
  logic [W-1:0]   m_slot [2];
  logic           m_ovf;
  logic           m_perr;
  logic [W-1:0]   q [$];
  logic [1:0]     gtab [4];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    wr = 0;
    rd = 0;
    ab = 0;
    m_slot[0] = '0;
    m_slot[1] = '0;
    m_ovf  = 1'b0;
    m_perr = 1'b0;
    q.delete();
  endtask

  task automatic check_regs();
    check_val("tptr",  bus.tptr,  gtab[wr % 4]);
    check_val("tdata", bus.tdata, {m_slot[1], m_slot[0]});
    check_val("rovf",  bus.rovf,  m_ovf);
    check_val("rperr", bus.rperr, m_perr);
  endtask

  // One clock cycle: apply inputs, check combinational outputs, clock, update
  // the model and check registered outputs.
  task automatic step(input bit put, input logic [W-1:0] d, input bit clr, input int ab_n);
    int cnt;
    bit rdy;
    bus.rput     = put;
    bus.rdata    = d;
    bus.rclr     = clr;
    ab           = ab_n & 3;
    bus.rq2_aptr = gtab[ab];
    #1;
    cnt = (wr - ab) & 3;
    rdy = (cnt < 2);
    check_val("rrdy",    bus.rrdy,    rdy);
    check_val("rstatus", bus.rstatus, (cnt == 0) ? 0 : ((cnt == 1) ? 1 : 2));
    @(posedge rclk);
    if (put && rdy) begin
      m_slot[wr % 2] = d;
      q.push_back(d);
      wr++;
    end
    m_ovf  = (put && cnt == 2) ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_perr = (cnt == 3)        ? 1'b1 : (clr ? 1'b0 : m_perr);
    @(negedge rclk);
    check_regs();
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic do_reset();
    bus.rput     = 1'b0;
    bus.rdata    = '0;
    bus.rclr     = 1'b0;
    bus.rq2_aptr = 2'b00;
    #2;
    rrst_n = 1'b0;
    #1;
    check_val("rst_tptr",  bus.tptr,  0);
    check_val("rst_tdata", bus.tdata, 0);
    check_val("rst_rovf",  bus.rovf,  0);
    check_val("rst_rperr", bus.rperr, 0);
    model_reset();
    @(negedge rclk);
    rrst_n = 1'b1;
    #1;
    check_val("rst_rrdy",    bus.rrdy,    1);
    check_val("rst_rstatus", bus.rstatus, 0);
  endtask

  initial begin
    gtab[0] = 2'b00;
    gtab[1] = 2'b01;
    gtab[2] = 2'b11;
    gtab[3] = 2'b10;
    model_reset();
    bus.rput     = 1'b0;
    bus.rdata    = '0;
    bus.rclr     = 1'b0;
    bus.rq2_aptr = 2'b00;

    // Power-on reset state.
    repeat (2) @(negedge rclk);
    rrst_n = 1'b1;
    #1;
    check_val("init_tptr",    bus.tptr,    0);
    check_val("init_rrdy",    bus.rrdy,    1);
    check_val("init_rstatus", bus.rstatus, 0);
    check_val("init_rovf",    bus.rovf,    0);
    check_val("init_tdata",   bus.tdata,   0);
    @(negedge rclk);

    // Single put, then fill to FULL, overflow, and clear behaviour.
    step(1'b1, 8'hA5, 1'b0, 0);
    check_val("put1_tptr", bus.tptr, 2'b01);
    check_val("put1_low",  bus.tdata[7:0], 8'hA5);
    check_val("put1_part", bus.rstatus, 1);
    step(1'b1, 8'h3C, 1'b0, 0);
    check_val("full_tptr", bus.tptr, 2'b11);
    check_val("full_rrdy", bus.rrdy, 0);
    step(1'b1, 8'h77, 1'b0, 0);
    check_val("ovf_set", bus.rovf, 1);
    step(1'b1, 8'h55, 1'b1, 0);
    check_val("ovf_set_wins", bus.rovf, 1);
    step(1'b0, 8'h00, 1'b1, 0);
    check_val("ovf_clr", bus.rovf, 0);
    step(1'b1, 8'h66, 1'b0, 0);

    // Reset while FULL, then stream with the ack pointer stepping along.
    do_reset();
    step(1'b1, 8'h11, 1'b0, 0);
    step(1'b1, 8'h22, 1'b0, 1);
    step(1'b1, 8'h33, 1'b0, 2);
    step(1'b1, 8'h44, 1'b0, 3);
    check_val("wrap_tptr", bus.tptr, 2'b00);
    step(1'b0, 8'h00, 1'b0, 0);

    // Remote ahead of transmitter.
    do_reset();
    step(1'b0, 8'h00, 1'b0, 1);
    check_val("perr_set", bus.rperr, 1);
    step(1'b1, 8'h99, 1'b0, 1);
    step(1'b0, 8'h00, 1'b1, 0);
    check_val("perr_clr", bus.rperr, 0);

    // Randomized traffic against a modelled remote receiver.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if ((wr - rd) > 0 && $urandom_range(0, 2) != 0) begin
        check_val("rx_data", bus.tdata[(rd % 2) * W +: W], q[0]);
        void'(q.pop_front());
        rd++;
      end
      step(1'($urandom_range(0, 1)), W'($urandom), ($urandom_range(0, 7) == 0), rd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rtx_mcp.md
RTX_MCP -- requirements
Module: rtx_mcp

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits.
REQ-002 rclk  input  1  clock, rising-edge; all state in this domain.
REQ-003 rrst_n  input  1  reset, asynchronous, active-low.
REQ-004 rput  input  1  source requests to send rdata this cycle.
REQ-005 rdata  input  WIDTH  word to send; sampled only on accepted put.
REQ-006 rclr  input  1  synchronous clear of sticky error flags.
REQ-007 rq2_aptr  input  2  remote acknowledge pointer, Gray, already two-flop synchronized into rclk.
REQ-008 rrdy  output  1  a free slot exists; put accepted this cycle if rput=1.
REQ-009 tptr  output  2  transmit pointer, Gray, registered; crosses to the remote receiver.
REQ-010 tdata  output  2*WIDTH  slot memory, slot1 in upper half; remote side selects a slot by its pointer.
REQ-011 rstatus  output  2  occupancy state: 0 EMPTY, 1 PART, 2 FULL.
REQ-012 rovf  output  1  sticky: put attempted while full.
REQ-013 rperr  output  1  sticky: illegal remote pointer distance seen.

Function
REQ-014 Internal binary pointer tbin[1:0]; tptr SHALL equal registered tbin ^ (tbin>>1).
REQ-015 Remote binary abin = Gray-to-binary of rq2_aptr; count = (tbin - abin) mod 4.
REQ-016 full SHALL be asserted when tptr == {~rq2_aptr[1], ~rq2_aptr[0]}, i.e. count==2.
REQ-017 rrdy SHALL be ~full and ~(count==3); combinational from registered state and rq2_aptr.
REQ-018 Accept rinc = rput & rrdy; on rinc, slot tbin[0] <= rdata, tbin <= tbin+1, both at the same edge.
REQ-019 Latency: accepted word visible on tdata and tptr advanced one rclk edge after the accepting edge.
REQ-020 Pointer wraps 3->0 (Gray 10->00) without any special handling; only one Gray bit changes per increment.
REQ-021 Slot not addressed by rinc SHALL hold its value; unaccepted rdata is never written.
REQ-022 rstatus: count 0 -> EMPTY, 1 -> PART, 2 -> FULL; count 3 -> FULL.
REQ-023 Put while full: no write, no pointer change, rovf <= 1 next edge.
REQ-024 count==3 (remote ahead of transmitter): rperr <= 1 next edge, rrdy=0 until count legal.
REQ-025 rclr clears rovf/rperr next edge; a set condition in the same cycle wins (flag stays 1).
REQ-026 Ack and put in the same cycle: put judged on current rq2_aptr; freed slot usable the following cycle.

Reset
REQ-027 rrst_n low: tbin=0, tptr=00, tdata=0, rovf=0, rperr=0 immediately, regardless of clock.
REQ-028 Reset mid-transfer discards all slots; remote side SHALL be reset concurrently (system requirement).
REQ-029 After release with rq2_aptr=00: rrdy=1, rstatus=EMPTY.

Structure
REQ-030 Shared package holds enum status_e {EMPTY, PART, FULL} and Gray/binary conversion functions.
REQ-031 One sub-module tx_mem2: 2-entry WIDTH register file, write-enable + 1-bit address, both entries exposed.
REQ-032 Pointer/flag logic in rtx_mcp top; no additional synchronizer inside (input already synchronized).

Verification
REQ-033 Reset, rq2_aptr=00 -> tptr=00, rrdy=1, rstatus=0, rovf=0, tdata=0.
REQ-034 rput=1, rdata=8'hA5 one cycle -> next edge tptr=01, tdata[7:0]=A5, rstatus=PART.
REQ-035 Puts A5, 3C with aptr held 00 -> tptr=11, rrdy=0, FULL; third put 77 -> no write, rovf=1; rclr -> rovf=0.
REQ-036 Step aptr 01,11,10,00 while putting 4 words -> tptr sequence 01,11,10,00, slots alternate, no loss, no rovf.
REQ-037 Drive rq2_aptr=01 while tptr=00 (count 3) -> rperr=1, rrdy=0.
REQ-038 Assert rrst_n low between clock edges while FULL -> outputs at reset values before next rclk edge.
